// File: rtl/gerador_de_status.sv
// gerador_de_status: weapon status sequencer producing code (A,B).
// DESLIGADO=00, PREPARACAO=10, ATAQUE=11; 01 is illegal and recovers to 00.
// Enforces a minimum preparation time before firing and a fixed attack length.

module gerador_de_status #(
   parameter int unsigned PREP_CICLOS = 8,
   parameter int unsigned ATK_CICLOS  = 4,
   parameter int unsigned CW          = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic LIGA,
   input  logic DESLIGA,
   input  logic DISPARO,
   output logic A,
   output logic B,
   output logic PRONTO
);

   // Encoding doubles as the output code, so A/B come straight from the register.
   typedef enum logic [1:0] {
      StDesligado  = 2'b00,
      StIlegal     = 2'b01,
      StPreparacao = 2'b10,
      StAtaque     = 2'b11
   } state_e;

   localparam logic [CW-1:0] LP_PREP    = CW'(PREP_CICLOS);
   localparam logic [CW-1:0] LP_ATK_ULT = CW'(ATK_CICLOS - 1);

   // Kept as plain bits so an upset into the illegal code is representable.
   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   state_e        w_state_next;
   logic [CW-1:0] w_cnt_next;
   logic          w_pronto;

   // Preparation complete: decoded from registers only.
   always_comb begin
      w_pronto = (r_state == StPreparacao) && (r_cnt == LP_PREP);
   end

   // Next-state and counter: DESLIGA beats every state-specific transition.
   always_comb begin
      w_state_next = state_e'(r_state);
      w_cnt_next   = r_cnt;
      if (DESLIGA) begin
         w_state_next = StDesligado;
         w_cnt_next   = '0;
      end else begin
         case (r_state)
            StDesligado: begin
               w_cnt_next = '0;
               if (LIGA) begin
                  w_state_next = StPreparacao;
               end
            end
            StPreparacao: begin
               if (w_pronto && DISPARO) begin
                  w_state_next = StAtaque;
                  w_cnt_next   = '0;
               end else if (r_cnt < LP_PREP) begin
                  // Saturates at the preparation time; never wraps.
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
            StAtaque: begin
               if (r_cnt == LP_ATK_ULT) begin
                  w_state_next = StPreparacao;
                  w_cnt_next   = '0;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
            default: begin
               w_state_next = StDesligado;
               w_cnt_next   = '0;
            end
         endcase
      end
   end

   // State and counter registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= StDesligado;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Output code is the state register itself.
   always_comb begin
      A      = r_state[1];
      B      = r_state[0];
      PRONTO = w_pronto;
   end

endmodule
